// File: rtl/unsort_scatter.sv
// Scatters a sorted frame back to original positions: buffer[index[j]] = data[j], LANES entries per clock.
// Optional duplicate-write detection is enabled by defining UNSORT_DUP_CHECK_EN; NETWORK_WIDTH/INDEX_WIDTH track core_params.svh.
module unsort_scatter #(
    parameter int SIZE          = 4,
    parameter int LANES         = 1,
    parameter int NETWORK_WIDTH = 16,
    parameter int INDEX_WIDTH   = 3
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [SIZE-1:0][NETWORK_WIDTH-1:0]  data_in,
    input  logic [SIZE-1:0][INDEX_WIDTH-1:0]    index_in,
    input  logic                                ack,
    output logic                                busy,
    output logic                                done,
    output logic [SIZE-1:0][NETWORK_WIDTH-1:0]  data_out,
    output logic                                err_range,
    output logic                                err_dup
);

    localparam int NCYC = (SIZE + LANES - 1) / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int SW   = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCATTER, S_DONE} state_t;

    state_t                              r_state;
    state_t                              w_state_next;
    logic [CW-1:0]                       r_cycle;
    logic [SIZE-1:0][NETWORK_WIDTH-1:0]  r_data;
    logic [SIZE-1:0][INDEX_WIDTH-1:0]    r_index;
    logic [SIZE-1:0][NETWORK_WIDTH-1:0]  r_buf;
    logic [SIZE-1:0][NETWORK_WIDTH-1:0]  w_buf_next;
    logic                                r_err_range;
    logic                                w_range_hit;
    logic                                w_accept;
    logic                                w_last;
    logic [SW-1:0]                       w_pos;
    int                                  w_j;

`ifdef UNSORT_DUP_CHECK_EN
    logic [SIZE-1:0]                     r_written;
    logic [SIZE-1:0]                     w_mark;
    logic                                r_err_dup;
    logic                                w_dup_hit;
`endif

    // A start is only honoured outside SCATTER; in DONE it doubles as the ack.
    assign w_accept = start && (r_state != S_SCATTER);
    assign w_last   = (r_cycle == CW'(NCYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start)  w_state_next = S_SCATTER;
            S_SCATTER: if (w_last) w_state_next = S_DONE;
            S_DONE: begin
                if (start)    w_state_next = S_SCATTER;
                else if (ack) w_state_next = S_IDLE;
            end
            default:          w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_SCATTER);
        done = (r_state == S_DONE);
    end

    // Lanes are walked in ascending order, so a higher lane overwrites a lower one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_buf_next  = r_buf;
        w_range_hit = 1'b0;
        w_pos       = '0;
        w_j         = 0;
`ifdef UNSORT_DUP_CHECK_EN
        w_mark      = r_written;
        w_dup_hit   = 1'b0;
`endif
        if (r_state == S_SCATTER) begin
            for (int k = 0; k < LANES; k++) begin
                w_j = int'(r_cycle) * LANES + k;
                if (w_j < SIZE) begin
                    if (int'(r_index[SW'(w_j)]) >= SIZE) begin
                        w_range_hit = 1'b1;
                    end else begin
                        w_pos             = SW'(r_index[SW'(w_j)]);
                        w_buf_next[w_pos] = r_data[SW'(w_j)];
`ifdef UNSORT_DUP_CHECK_EN
                        if (w_mark[w_pos]) w_dup_hit = 1'b1;
                        w_mark[w_pos] = 1'b1;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the result buffer is a flop array, not a RAM, so resetting it is legal and cheap.
        if (!reset_n) begin
            r_data      <= '0;
            r_index     <= '0;
            r_buf       <= '0;
            r_cycle     <= '0;
            r_err_range <= 1'b0;
        end else if (w_accept) begin
            r_data      <= data_in;
            r_index     <= index_in;
            r_buf       <= '0;
            r_cycle     <= '0;
            r_err_range <= 1'b0;
        end else if (r_state == S_SCATTER) begin
            r_buf       <= w_buf_next;
            r_cycle     <= r_cycle + CW'(1);
            r_err_range <= r_err_range | w_range_hit;
        end
    end

`ifdef UNSORT_DUP_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_written <= '0;
            r_err_dup <= 1'b0;
        end else if (w_accept) begin
            r_written <= '0;
            r_err_dup <= 1'b0;
        end else if (r_state == S_SCATTER) begin
            r_written <= w_mark;
            r_err_dup <= r_err_dup | w_dup_hit;
        end
    end

    assign err_dup = r_err_dup;
`else
    assign err_dup = 1'b0;
`endif

    assign data_out  = r_buf;
    assign err_range = r_err_range;

endmodule
